// File: rtl/mem_stage_pkg.sv
// Shared opcodes, FSM encoding and access-classification helpers for the MEM stage.
package mem_stage_pkg;

    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpLb  = 6'h20;
    localparam logic [5:0] OpLbu = 6'h24;
    localparam logic [5:0] OpLh  = 6'h21;
    localparam logic [5:0] OpLhu = 6'h25;
    localparam logic [5:0] OpSw  = 6'h2B;
    localparam logic [5:0] OpSb  = 6'h28;
    localparam logic [5:0] OpSh  = 6'h29;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } mem_state_e;

    function automatic logic is_store(logic [5:0] op);
        return (op == OpSw) || (op == OpSh) || (op == OpSb);
    endfunction

    function automatic logic is_mem(logic [5:0] op);
        return is_store(op) || (op == OpLw) || (op == OpLb) || (op == OpLbu) ||
               (op == OpLh) || (op == OpLhu);
    endfunction

    // Non-memory opcodes are never misaligned.
    function automatic logic misaligned(logic [5:0] op, logic [1:0] addr_lo);
        logic bad;
        case (op)
            OpLh, OpLhu, OpSh: bad = addr_lo[0];
            OpLw, OpSw:        bad = (addr_lo != 2'b00);
            default:           bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, replicated store data, misalign flag and
// extended load data for the access currently held in M.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] raw_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte / half-word out of the raw bus word.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = raw_rdata[7:0];
            2'd1:    byte_lane = raw_rdata[15:8];
            2'd2:    byte_lane = raw_rdata[23:16];
            default: byte_lane = raw_rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? raw_rdata[31:16] : raw_rdata[15:0];
    end

    // Store lanes; loads read the whole word, so all enables are on.
    always_comb begin
        case (op)
            OpSb: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            OpSh: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            OpSw: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            OpLw, OpLb, OpLbu, OpLh, OpLhu: begin
                be    = 4'b1111;
                wdata = 32'h0;
            end
            default: begin
                be    = 4'b0000;
                wdata = 32'h0;
            end
        endcase
    end

    // Load extension; stores and non-memory ops return zero.
    always_comb begin
        case (op)
            OpLb:    load_data = {{24{byte_lane[7]}}, byte_lane};
            OpLbu:   load_data = {24'h0, byte_lane};
            OpLh:    load_data = {{16{half_lane[15]}}, half_lane};
            OpLhu:   load_data = {16'h0, half_lane};
            OpLw:    load_data = raw_rdata;
            default: load_data = 32'h0;
        endcase
    end

    assign misalign = misaligned(op, addr_lo);

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX/MEM pipeline register plus a req/ack data-memory access engine
// that stalls upstream stages while an access is outstanding.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16  // ACCESS cycles before bus error; 0 disables
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrE,
    input  logic [31:0] alu_outE,
    input  logic [31:0] write_dataE,
    input  logic [31:0] pc_plus8E,
    output logic [31:0] instrM,
    output logic [31:0] alu_outM,
    output logic [31:0] pc_plus8M,
    output logic [31:0] read_dataM,
    output logic        stallM,
    output logic        addr_errM,
    output logic        bus_errM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    mem_state_e  state_q, state_d;
    logic [31:0] store_data_q;
    logic [31:0] cnt_q;
    logic        start_access;
    logic        timeout_hit;
    logic        in_access;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        misalign;

    mem_align u_align (
        .op         (instrM[31:26]),
        .addr_lo    (alu_outM[1:0]),
        .store_data (store_data_q),
        .raw_rdata  (dmem_rdata),
        .be         (be),
        .wdata      (wdata),
        .misalign   (misalign),
        .load_data  (load_data)
    );

    assign in_access    = (state_q == StAccess);
    assign start_access = is_mem(instrE[31:26]) && !misaligned(instrE[31:26], alu_outE[1:0]);
    assign timeout_hit  = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 32'd1) && !dmem_ack;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE and DONE both capture, so they share the same decision.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: state_d = start_access ? StAccess : StIdle;
            StAccess: begin
                if (dmem_ack || timeout_hit) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus and status outputs; request-side fields are only driven during ACCESS.
    always_comb begin
        stallM     = in_access;
        dmem_req   = in_access;
        dmem_we    = in_access && is_store(instrM[31:26]);
        dmem_be    = in_access ? be : 4'b0000;
        dmem_wdata = in_access ? wdata : 32'h0;
        dmem_addr  = {alu_outM[31:2], 2'b00};
        addr_errM  = misalign;
    end

    // M registers: capture whenever not stalled, otherwise run the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instrM       <= 32'h0;
            alu_outM     <= 32'h0;
            pc_plus8M    <= 32'h0;
            store_data_q <= 32'h0;
            read_dataM   <= 32'h0;
            bus_errM     <= 1'b0;
            cnt_q        <= 32'h0;
        end else if (!in_access) begin
            instrM       <= instrE;
            alu_outM     <= alu_outE;
            pc_plus8M    <= pc_plus8E;
            store_data_q <= write_dataE;
            bus_errM     <= 1'b0;
            cnt_q        <= 32'h0;
            // Non-memory capture keeps the previous load result.
            if (misaligned(instrE[31:26], alu_outE[1:0])) begin
                read_dataM <= 32'h0;
            end
        end else begin
            cnt_q <= cnt_q + 32'd1;
            if (dmem_ack) begin
                read_dataM <= load_data;
            end else if (timeout_hit) begin
                bus_errM   <= 1'b1;
                read_dataM <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed program, bus responder with per-op wait
// states, a transaction-level model compared every cycle, and literal spot checks.
module tb_mem_stage;

    localparam int unsigned TIMEOUT = 16;

    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SW  = 6'h2B;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] ALU = 6'h00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instrE = '0, alu_outE = '0, write_dataE = '0, pc_plus8E = '0;
    logic [31:0] instrM, alu_outM, pc_plus8M, read_dataM;
    logic        stallM, addr_errM, bus_errM, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .instrE      (instrE),
        .alu_outE    (alu_outE),
        .write_dataE (write_dataE),
        .pc_plus8E   (pc_plus8E),
        .instrM      (instrM),
        .alu_outM    (alu_outM),
        .pc_plus8M   (pc_plus8M),
        .read_dataM  (read_dataM),
        .stallM      (stallM),
        .addr_errM   (addr_errM),
        .bus_errM    (bus_errM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] instr;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] pc8;
        int          waits;  // ack in ACCESS cycle #waits; -1 = never
        logic [31:0] rdata;
    } op_t;

    op_t prog[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic add_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input int waits, input logic [31:0] rdata);
        op_t o;
        o.op    = op;
        o.instr = {op, 10'd0, 16'(prog.size() + 1)};
        o.addr  = addr;
        o.rt    = rt;
        o.pc8   = 32'h0040_0008 + 32'(prog.size() * 4);
        o.waits = waits;
        o.rdata = rdata;
        prog.push_back(o);
    endtask

    function automatic op_t get_op(int i);
        op_t o;
        if (i < prog.size()) begin
            o = prog[i];
        end else begin
            o.op = '0; o.instr = '0; o.addr = '0; o.rt = '0; o.pc8 = '0;
            o.waits = 0; o.rdata = '0;
        end
        return o;
    endfunction

    // ---------------- reference model (size/lane arithmetic) ----------------
    function automatic int size_of(logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        if (op == LW || op == SW) return 4;
        return 0;
    endfunction

    function automatic bit is_st(logic [5:0] op);
        return op == SB || op == SH || op == SW;
    endfunction

    function automatic bit misal(logic [5:0] op, logic [31:0] addr);
        int sz = size_of(op);
        return sz != 0 && (int'(addr % 4) % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(logic [5:0] op, logic [31:0] addr,
                                               logic [31:0] rdata);
        longint v;
        logic [31:0] shifted;
        shifted = rdata >> (8 * int'(addr % 4));
        v = 0;
        v[31:0] = shifted;
        case (op)
            LB:  begin v = v % 256;   if (v >= 128) v = v - 256; end
            LBU: v = v % 256;
            LH:  begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            LHU: v = v % 65536;
            LW:  v[31:0] = rdata;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [3:0] model_be(logic [5:0] op, logic [31:0] addr);
        int lane = int'(addr % 4);
        if (op == SB) return 4'(1 << lane);
        if (op == SH) return 4'(3 << lane);
        if (size_of(op) != 0) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] model_wdata(logic [5:0] op, logic [31:0] rt);
        if (op == SB) return (rt & 32'hFF) * 32'h0101_0101;
        if (op == SH) return (rt & 32'hFFFF) * 32'h0001_0001;
        return rt;
    endfunction

    // ---------------- driver / responder state ----------------
    int cur = 0;
    int m_idx = -1;
    int acc_n = 0;
    bit prev_req = 0;
    bit model_on = 0;
    bit done = 0;
    bit stall_before = 0;

    int          occ[32];
    int          stl[32];
    logic [31:0] rd_seen[32];
    logic [3:0]  be_seen[32];
    logic [31:0] wd_seen[32];
    bit          req_seen[32];
    bit          aerr_seen[32];
    bit          berr_seen[32];

    // ---------------- model state + per-cycle compare ----------------
    logic [31:0] m_instr = '0, m_alu = '0, m_pc8 = '0, m_rt = '0, m_rd = '0;
    logic [5:0]  m_op = '0;
    bit          m_aerr = 0, m_berr = 0, pend_berr = 0;
    logic [31:0] pend_rd = '0;
    int          left = 0;

    always @(negedge clk) begin
        if (model_on) begin
            op_t o;
            chk("instrM", instrM, m_instr);
            chk("alu_outM", alu_outM, m_alu);
            chk("pc_plus8M", pc_plus8M, m_pc8);
            chk("read_dataM", read_dataM, m_rd);
            chk_b("stallM", stallM, left > 0);
            chk_b("dmem_req", dmem_req, left > 0);
            chk_b("addr_errM", addr_errM, m_aerr);
            chk_b("bus_errM", bus_errM, m_berr);
            chk("dmem_addr", dmem_addr, m_alu & ~32'h3);
            if (left > 0) begin
                chk_b("dmem_we", dmem_we, is_st(m_op));
                chk("dmem_be", {28'h0, dmem_be}, {28'h0, model_be(m_op, m_alu)});
                if (is_st(m_op)) chk("dmem_wdata", dmem_wdata, model_wdata(m_op, m_rt));
            end
            // Predict the state after the coming edge.
            if (left > 0) begin
                left = left - 1;
                if (left == 0) begin
                    m_rd   = pend_rd;
                    m_berr = pend_berr;
                end
            end else begin
                o       = get_op(cur);
                m_instr = o.instr;
                m_alu   = o.addr;
                m_pc8   = o.pc8;
                m_rt    = o.rt;
                m_op    = o.op;
                m_berr  = 0;
                m_aerr  = misal(o.op, o.addr);
                if (m_aerr) begin
                    m_rd = '0;
                end else if (size_of(o.op) != 0) begin
                    if (o.waits >= 0 && o.waits < int'(TIMEOUT)) begin
                        left      = o.waits + 1;
                        pend_rd   = is_st(o.op) ? 32'h0 : model_load(o.op, o.addr, o.rdata);
                        pend_berr = 0;
                    end else begin
                        left      = int'(TIMEOUT);
                        pend_rd   = '0;
                        pend_berr = 1;
                    end
                end
            end
        end
    end

    task automatic drive(input int cyc);
        op_t o;
        o = get_op(cur);
        instrE      = o.instr;
        alu_outE    = o.addr;
        write_dataE = o.rt;
        pc_plus8E   = o.pc8;
        if (dmem_req) begin
            acc_n      = prev_req ? acc_n + 1 : 0;
            dmem_ack   = (m_idx >= 0) && (prog[m_idx].waits >= 0) && (acc_n == prog[m_idx].waits);
            dmem_rdata = (m_idx >= 0) ? prog[m_idx].rdata : 32'h0;
        end else begin
            // Stray acks outside ACCESS must be ignored.
            dmem_ack   = cyc[0];
            dmem_rdata = 32'hA5A5_A5A5;
        end
        prev_req = dmem_req;
    endtask

    task automatic record();
        if (m_idx >= 0) begin
            occ[m_idx]++;
            if (stallM) stl[m_idx]++;
            if (dmem_req) begin
                req_seen[m_idx] = 1;
                be_seen[m_idx]  = dmem_be;
                wd_seen[m_idx]  = dmem_wdata;
            end
            rd_seen[m_idx] = read_dataM;
            if (addr_errM) aerr_seen[m_idx] = 1;
            if (bus_errM) berr_seen[m_idx] = 1;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            occ[i] = 0; stl[i] = 0; rd_seen[i] = '0; be_seen[i] = '0; wd_seen[i] = '0;
            req_seen[i] = 0; aerr_seen[i] = 0; berr_seen[i] = 0;
        end
        add_op(LW,  32'h0000_0100, 32'h0,         0,  32'hDEAD_BEEF);  // 0
        add_op(LB,  32'h0000_0103, 32'h0,         1,  32'h80FF_0000);  // 1
        add_op(LHU, 32'h0000_0102, 32'h0,         0,  32'h80FF_0000);  // 2
        add_op(ALU, 32'h0000_0055, 32'h0,         0,  32'h0);          // 3
        add_op(SB,  32'h0000_0201, 32'h9999_9912, 3,  32'h0);          // 4
        add_op(SH,  32'h0000_0202, 32'h1111_ABCD, 2,  32'h0);          // 5
        add_op(SW,  32'h0000_0204, 32'hCAFE_F00D, 0,  32'h0);          // 6
        add_op(ALU, 32'h0000_0077, 32'h0,         0,  32'h0);          // 7
        add_op(LW,  32'h0000_0102, 32'h0,         0,  32'h1234_5678);  // 8 misaligned
        add_op(LH,  32'h0000_0106, 32'h0,         0,  32'h8001_1234);  // 9
        add_op(LBU, 32'h0000_0100, 32'h0,         2,  32'h0000_00F0);  // 10
        add_op(LW,  32'h0000_0300, 32'h0,         -1, 32'h0);          // 11 timeout
        add_op(LH,  32'h0000_0203, 32'h0,         0,  32'h0);          // 12 misaligned
        add_op(ALU, 32'h0000_0099, 32'h0,         0,  32'h0);          // 13

        // Reset values.
        @(negedge clk); @(negedge clk);
        chk("rst_instrM", instrM, 32'h0);
        chk("rst_alu_outM", alu_outM, 32'h0);
        chk("rst_pc_plus8M", pc_plus8M, 32'h0);
        chk("rst_read_dataM", read_dataM, 32'h0);
        chk_b("rst_stallM", stallM, 1'b0);
        chk_b("rst_dmem_req", dmem_req, 1'b0);
        chk_b("rst_addr_errM", addr_errM, 1'b0);
        chk_b("rst_bus_errM", bus_errM, 1'b0);
        chk_b("rst_dmem_we", dmem_we, 1'b0);
        chk("rst_dmem_be", {28'h0, dmem_be}, 32'h0);
        chk("rst_dmem_wdata", dmem_wdata, 32'h0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        reset = 1'b1;

        @(posedge clk); #1;
        model_on = 1;
        drive(0);
        for (int cyc = 1; cyc < 600; cyc++) begin
            stall_before = stallM;
            @(posedge clk); #1;
            if (!stall_before) begin
                if (cur < prog.size()) begin
                    m_idx = cur;
                    cur++;
                end else begin
                    m_idx = -1;
                end
            end
            if (cur >= prog.size() && m_idx < 0) begin
                done = 1;
                break;
            end
            record();
            drive(cyc);
        end
        model_on = 0;
        chk_b("program_retired", done, 1'b1);

        chk("lw_stall", 32'(stl[0]), 32'd1);
        chk("lw_occ", 32'(occ[0]), 32'd2);
        chk("lw_data", rd_seen[0], 32'hDEAD_BEEF);
        chk("lb_data", rd_seen[1], 32'hFFFF_FF80);
        chk("lhu_data", rd_seen[2], 32'h0000_80FF);
        chk("alu_keeps_rd", rd_seen[3], 32'h0000_80FF);
        chk("alu_occ", 32'(occ[3]), 32'd1);
        chk("sb_be", {28'h0, be_seen[4]}, 32'h2);
        chk("sb_wdata", wd_seen[4], 32'h1212_1212);
        chk("sb_stall", 32'(stl[4]), 32'd4);
        chk("sh_be", {28'h0, be_seen[5]}, 32'hC);
        chk("sh_wdata", wd_seen[5], 32'hABCD_ABCD);
        chk("sw_occ", 32'(occ[6]), 32'd2);
        chk("add_after_sw_occ", 32'(occ[7]), 32'd1);
        chk_b("mis_lw_aerr", aerr_seen[8], 1'b1);
        chk_b("mis_lw_noreq", req_seen[8], 1'b0);
        chk("mis_lw_rd", rd_seen[8], 32'h0);
        chk("lh_data", rd_seen[9], 32'hFFFF_8001);
        chk("lbu_data", rd_seen[10], 32'h0000_00F0);
        chk_b("timeout_berr", berr_seen[11], 1'b1);
        chk("timeout_stall", 32'(stl[11]), 32'd16);
        chk("timeout_rd", rd_seen[11], 32'h0);
        chk_b("mis_lh_aerr", aerr_seen[12], 1'b1);

        // Reset in the middle of an access.
        instrE = {LW, 10'd0, 16'h00AA}; alu_outE = 32'h400; write_dataE = '0;
        pc_plus8E = 32'h1234; dmem_ack = 1'b0;
        @(posedge clk); #1;
        instrE = '0; alu_outE = '0; pc_plus8E = '0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk_b("pre_reset_stall", stallM, 1'b1);
        reset = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        #1;
        chk_b("mid_rst_req", dmem_req, 1'b0);
        chk_b("mid_rst_stall", stallM, 1'b0);
        chk("mid_rst_instrM", instrM, 32'h0);
        chk("mid_rst_alu_outM", alu_outM, 32'h0);
        chk("mid_rst_pc_plus8M", pc_plus8M, 32'h0);
        chk_b("mid_rst_bus_errM", bus_errM, 1'b0);
        @(posedge clk); #1;
        chk("mid_rst_read_dataM", read_dataM, 32'h0);
        chk_b("mid_rst_req_hold", dmem_req, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        dmem_ack = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
